// File: rtl/ife_pkg.sv
// Shared types and helpers for the instruction-flow block dispatcher.
package ife_pkg;

  localparam int DESC_ADDR_W = 32;
  localparam int DESC_TAG_W  = 4;

  typedef enum logic [1:0] {IDLE, SELECT, LAUNCH} disp_state_e;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] pc;
    logic [DESC_TAG_W-1:0]  tag;
  } blk_desc_t;

  function automatic int core_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ife_rr_picker.sv
// Combinational round-robin picker: first set bit of avail at or above rr_ptr, with wrap.
module ife_rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] avail,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     sel
);

  logic [2*NUM_CORES-1:0] dbl;
  logic [NUM_CORES-1:0]   rot;
  logic [IDX_W:0]         off;
  logic [IDX_W:0]         sum;

  // Rotating a doubled copy right by rr_ptr puts rr_ptr at bit 0.
  assign dbl = {avail, avail} >> rr_ptr;
  assign rot = dbl[NUM_CORES-1:0];

  always_comb begin
    off = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (rot[i]) off = (IDX_W+1)'(i);
  end

  assign found = |avail;
  assign sum   = {1'b0, rr_ptr} + off;
  assign sel   = (sum >= (IDX_W+1)'(NUM_CORES)) ? IDX_W'(sum - (IDX_W+1)'(NUM_CORES))
                                                : sum[IDX_W-1:0];

endmodule

// File: rtl/ife_dispatcher.sv
// Dispatches flow blocks to idle cores round-robin and reports completions with their tags.
module ife_dispatcher
  import ife_pkg::*;
#(
  parameter int  NUM_CORES  = 4,
  parameter int  ADDR_W     = 32,
  parameter int  TAG_W      = 4,
  localparam int CORE_IDX_W = core_idx_w(NUM_CORES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_pc,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [NUM_CORES-1:0]  core_idle_mask,
  output logic [NUM_CORES-1:0]  disp_valid,
  output logic [ADDR_W-1:0]     disp_pc,
  output logic [TAG_W-1:0]      disp_tag,
  input  logic [NUM_CORES-1:0]  disp_ack,
  input  logic [NUM_CORES-1:0]  core_done,
  output logic                  cmpl_valid,
  output logic [CORE_IDX_W-1:0] cmpl_core,
  output logic [TAG_W-1:0]      cmpl_tag,
  output logic                  err_spurious
);

  disp_state_e                        state;
  logic [CORE_IDX_W-1:0]              rr_ptr, sel, sel_q, sel_nxt, pend_idx;
  logic                               found;
  logic [NUM_CORES-1:0]               reserved, pend, avail, done_ok, ack_hit, pend_low;
  logic [NUM_CORES-1:0][TAG_W-1:0]    tag_table;

  assign avail = core_idle_mask & ~reserved;

  ife_rr_picker #(.NUM_CORES(NUM_CORES), .IDX_W(CORE_IDX_W)) u_pick (
    .avail  (avail),
    .rr_ptr (rr_ptr),
    .found  (found),
    .sel    (sel)
  );

  assign req_ready = rst_n && (state == IDLE);
  assign ack_hit   = (state == LAUNCH && disp_ack[sel_q]) ? (NUM_CORES'(1) << sel_q) : '0;
  // A done on an unreserved core (including one being acked now) never reaches pend.
  assign done_ok   = core_done & reserved;
  assign pend_low  = pend & (~pend + NUM_CORES'(1));
  assign sel_nxt   = (32'(sel_q) == NUM_CORES-1) ? '0 : sel_q + CORE_IDX_W'(1);

  always_comb begin
    pend_idx = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (pend[i]) pend_idx = CORE_IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      sel_q        <= '0;
      reserved     <= '0;
      pend         <= '0;
      tag_table    <= '0;
      disp_valid   <= '0;
      disp_pc      <= '0;
      disp_tag     <= '0;
      cmpl_valid   <= 1'b0;
      cmpl_core    <= '0;
      cmpl_tag     <= '0;
      err_spurious <= 1'b0;
    end else begin
      reserved   <= (reserved & ~done_ok) | ack_hit;
      pend       <= (pend & ~pend_low) | done_ok;
      cmpl_valid <= |pend;
      if (|pend) begin
        cmpl_core <= pend_idx;
        cmpl_tag  <= tag_table[pend_idx];
      end
      if (|(core_done & ~reserved)) err_spurious <= 1'b1;

      case (state)
        IDLE: if (req_valid) begin
          disp_pc  <= req_pc;
          disp_tag <= req_tag;
          state    <= SELECT;
        end
        SELECT: if (found) begin
          sel_q      <= sel;
          disp_valid <= NUM_CORES'(1) << sel;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          if (disp_ack[sel_q]) begin
            tag_table[sel_q] <= disp_tag;
            rr_ptr           <= sel_nxt;
            disp_valid       <= '0;
            state            <= IDLE;
          end else if (!core_idle_mask[sel_q]) begin
            // Core went busy before accepting: retry selection with the same block.
            disp_valid <= '0;
            state      <= SELECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ife_dispatcher.sv
// Directed self-checking bench for ife_dispatcher (4 cores).
module tb_ife_dispatcher;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_pc = '0;
  logic [TW-1:0] req_tag = '0;
  logic [N-1:0]  core_idle_mask = '0;
  logic [N-1:0]  disp_valid;
  logic [AW-1:0] disp_pc;
  logic [TW-1:0] disp_tag;
  logic [N-1:0]  disp_ack = '0;
  logic [N-1:0]  core_done = '0;
  logic          cmpl_valid;
  logic [IW-1:0] cmpl_core;
  logic [TW-1:0] cmpl_tag;
  logic          err_spurious;

  int checks = 0;
  int errors = 0;

  ife_dispatcher #(.NUM_CORES(N), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .req_tag        (req_tag),
    .core_idle_mask (core_idle_mask),
    .disp_valid     (disp_valid),
    .disp_pc        (disp_pc),
    .disp_tag       (disp_tag),
    .disp_ack       (disp_ack),
    .core_done      (core_done),
    .cmpl_valid     (cmpl_valid),
    .cmpl_core      (cmpl_core),
    .cmpl_tag       (cmpl_tag),
    .err_spurious   (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; disp_ack = '0; core_done = '0;
    #1;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_disp_pc", disp_pc, 0);
    chk("rst_cmpl_valid", cmpl_valid, 0);
    chk("rst_err", err_spurious, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", req_ready, 1);
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [TW-1:0] tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("push_ready", req_ready, 1);
    req_valid = 1'b1; req_pc = pc; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic launch(input int core, input logic [AW-1:0] pc, input logic [TW-1:0] tag);
    int n = 0;
    logic [N-1:0] exp_oh;
    exp_oh = N'(1) << core;
    @(negedge clk);
    while (disp_valid == '0 && n < 20) begin @(negedge clk); n++; end
    chk("launch_valid", disp_valid, exp_oh);
    chk("launch_pc", disp_pc, pc);
    chk("launch_tag", disp_tag, tag);
    disp_ack = disp_valid;
    @(posedge clk);
    #1 disp_ack = '0;
    chk("ack_ready", req_ready, 1);
    chk("ack_valid_drop", disp_valid, 0);
  endtask

  task automatic pulse_done(input logic [N-1:0] m);
    @(negedge clk);
    core_done = m;
    @(posedge clk);
    #1 core_done = '0;
  endtask

  task automatic wait_cmpl(input int core, input logic [TW-1:0] tag);
    int n = 0;
    @(negedge clk);
    while (!cmpl_valid && n < 20) begin @(negedge clk); n++; end
    chk("cmpl_valid", cmpl_valid, 1);
    chk("cmpl_core", cmpl_core, core);
    chk("cmpl_tag", cmpl_tag, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Four blocks fill cores 0..3; the fifth waits until core 1 completes.
    do_reset();
    core_idle_mask = 4'hF;
    for (int k = 0; k < 4; k++) begin
      push(AW'((k + 1) * 32'h100), TW'(k + 1));
      launch(k, AW'((k + 1) * 32'h100), TW'(k + 1));
    end
    push(32'h500, 4'd5);
    repeat (4) begin
      @(negedge clk);
      chk("all_reserved_wait", disp_valid, 0);
    end
    chk("select_not_ready", req_ready, 0);
    pulse_done(4'b0010);
    wait_cmpl(1, 4'd2);
    launch(1, 32'h500, 4'd5);
    chk("cmpl_single", cmpl_valid, 0);

    // Only core 2 idle: exact latency, then round-robin continues at core 3.
    do_reset();
    core_idle_mask = 4'b0100;
    push(32'h40, 4'd7);
    @(negedge clk);
    chk("lat_select", disp_valid, 0);
    @(negedge clk);
    chk("lat_launch", disp_valid, 4'b0100);
    launch(2, 32'h40, 4'd7);
    core_idle_mask = 4'hF;
    push(32'h44, 4'd8);
    launch(3, 32'h44, 4'd8);

    // Core 0 goes busy before acking: retarget to core 3, core 0 left unreserved.
    do_reset();
    core_idle_mask = 4'hF;
    push(32'h80, 4'd6);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre", disp_valid, 4'b0001);
    core_idle_mask = 4'b1000;
    @(negedge clk);
    chk("abort_drop", disp_valid, 0);
    launch(3, 32'h80, 4'd6);
    core_idle_mask = 4'hF;
    push(32'h90, 4'd7);
    launch(0, 32'h90, 4'd7);

    // Three simultaneous completions drain lowest index first.
    do_reset();
    core_idle_mask = 4'hF;
    push(32'hA0, 4'd5);  launch(0, 32'hA0, 4'd5);
    push(32'hB0, 4'd6);  launch(1, 32'hB0, 4'd6);
    push(32'hC0, 4'd9);  launch(2, 32'hC0, 4'd9);
    push(32'hD0, 4'd11); launch(3, 32'hD0, 4'd11);
    pulse_done(4'b1101);
    wait_cmpl(0, 4'd5);
    @(negedge clk);
    chk("drain2_valid", cmpl_valid, 1);
    chk("drain2_core", cmpl_core, 2);
    chk("drain2_tag", cmpl_tag, 9);
    @(negedge clk);
    chk("drain3_valid", cmpl_valid, 1);
    chk("drain3_core", cmpl_core, 3);
    chk("drain3_tag", cmpl_tag, 11);
    @(negedge clk);
    chk("drain_end", cmpl_valid, 0);
    chk("no_spurious", err_spurious, 0);
    push(32'hE0, 4'd1);
    launch(0, 32'hE0, 4'd1);

    // Spurious done on unreserved core 1: sticky error, no completion.
    do_reset();
    core_idle_mask = 4'hF;
    push(32'h10, 4'd2);
    launch(0, 32'h10, 4'd2);
    pulse_done(4'b0010);
    repeat (3) begin
      @(negedge clk);
      chk("spur_err", err_spurious, 1);
      chk("spur_no_cmpl", cmpl_valid, 0);
    end
    push(32'h20, 4'd3);
    launch(1, 32'h20, 4'd3);
    chk("spur_sticky", err_spurious, 1);

    // Reset in the middle of a launch.
    do_reset();
    core_idle_mask = 4'hF;
    push(32'h30, 4'd4);
    @(negedge clk);
    @(negedge clk);
    chk("mid_launch", disp_valid, 4'b0001);
    do_reset();
    push(32'h34, 4'd5);
    launch(0, 32'h34, 4'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
